// File: rtl/rotary_value_ctrl.sv
// Rotary-encoder setting register: turns detent ticks into a bounded value with clamp/wrap and preload.
// Define ROTARY_ACCEL_EN to enable speed acceleration (step 1/2/4/8 for fast same-direction turning).
module rotary_value_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MIN_VAL      = 0,
  parameter int unsigned MAX_VAL      = 255,
  parameter int unsigned INIT_VAL     = 0,
  parameter int unsigned WRAP         = 0,
  parameter int unsigned ACCEL_WINDOW = 50000,
  parameter int unsigned ACCEL_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             changed_o,
  output logic             dir_o,
  output logic             at_limit_o
);

  // Headroom bits so v+step and v-step never overflow before the limit checks.
  localparam int unsigned AW = WIDTH + 4;

  localparam logic [AW-1:0]    MIN_A       = AW'(MIN_VAL);
  localparam logic [AW-1:0]    MAX_A       = AW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_V       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_V      = WIDTH'(INIT_VAL);
  localparam logic             INIT_AT_LIM = (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);
  localparam logic             WRAP_EN     = (WRAP != 0);

  // Reject parameter sets the datapath cannot honour.
  if (MIN_VAL >= MAX_VAL || INIT_VAL < MIN_VAL || INIT_VAL > MAX_VAL) begin : g_bad_range
    $error("rotary_value_ctrl: need MIN_VAL < MAX_VAL and INIT_VAL within [MIN_VAL,MAX_VAL]");
  end
  if (ACCEL_W == 0 || (ACCEL_WINDOW >> ACCEL_W) != 0) begin : g_bad_accel
    $error("rotary_value_ctrl: ACCEL_WINDOW must fit in ACCEL_W bits");
  end

  logic [3:0]       step;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    diff;
  logic [AW-1:0]    load_a;
  logic [WIDTH-1:0] value_d;
  logic             dir_d;

`ifdef ROTARY_ACCEL_EN
  localparam logic [0:0]         ST_IDLE  = 1'b0;
  localparam logic [0:0]         ST_TRACK = 1'b1;
  localparam logic [ACCEL_W-1:0] WIN      = ACCEL_W'(ACCEL_WINDOW);

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic [1:0]         streak_q;
  logic [1:0]         streak_d;
  logic [ACCEL_W-1:0] interval_q;

  // Cycles since the last accepted tick, parked at WIN once rotation has gone quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interval_q <= WIN;
    end else if (tick_i && !load_i) begin
      interval_q <= '0;
    end else if (interval_q < WIN) begin
      interval_q <= interval_q + ACCEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      streak_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next state and streak; the streak only grows on fast ticks that keep the previous direction.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (load_i) begin
      state_d  = ST_IDLE;
      streak_d = 2'd0;
    end else if (tick_i) begin
      state_d = ST_TRACK;
      if (state_q == ST_TRACK && dir_i == dir_o) begin
        streak_d = (streak_q == 2'd3) ? 2'd3 : 2'(streak_q + 2'd1);
      end else begin
        streak_d = 2'd0;
      end
    end else if (state_q == ST_TRACK && interval_q >= WIN) begin
      state_d = ST_IDLE;
    end
  end

  assign step = 4'(4'd1 << streak_d);
`else
  assign step = 4'd1;
`endif

  assign sum    = AW'(value_o) + AW'(step);
  assign diff   = AW'(value_o) - AW'(step);
  assign load_a = AW'(load_val_i);

  // Next value: load clamps regardless of WRAP, ticks saturate or wrap at the limits.
  always_comb begin
    value_d = value_o;
    dir_d   = dir_o;
    if (load_i) begin
      if (load_a < MIN_A) begin
        value_d = MIN_V;
      end else if (load_a > MAX_A) begin
        value_d = MAX_V;
      end else begin
        value_d = load_val_i;
      end
    end else if (tick_i) begin
      dir_d = dir_i;
      if (dir_i) begin
        if (sum > MAX_A) begin
          value_d = WRAP_EN ? MIN_V : MAX_V;
        end else begin
          value_d = WIDTH'(sum);
        end
      end else begin
        if (AW'(value_o) < AW'(step) || diff < MIN_A) begin
          value_d = WRAP_EN ? MAX_V : MIN_V;
        end else begin
          value_d = WIDTH'(diff);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_o    <= INIT_V;
      changed_o  <= 1'b0;
      dir_o      <= 1'b0;
      at_limit_o <= INIT_AT_LIM;
    end else begin
      value_o    <= value_d;
      changed_o  <= (value_d != value_o);
      dir_o      <= dir_d;
      at_limit_o <= (value_d == MIN_V) || (value_d == MAX_V);
    end
  end

endmodule
